// File: rtl/pow2_lut_arbiter_if.sv
// Request/result bundle for the shared pow2 LUT: NUM_REQ request lanes in,
// one result port out with backpressure.
interface pow2_lut_arbiter_if #(
    parameter int NUM_REQ = 4
);
    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]   in_valid;
    logic [NUM_REQ*8-1:0] in_frac;
    logic [NUM_REQ-1:0]   in_ready;
    logic                 out_valid;
    logic [8:0]           out_data;
    logic [ID_W-1:0]      out_id;
    logic                 out_ready;

    modport slave (
        input  in_valid, in_frac, out_ready,
        output in_ready, out_valid, out_data, out_id
    );

    modport master (
        output in_valid, in_frac, out_ready,
        input  in_ready, out_valid, out_data, out_id
    );
endinterface

// File: rtl/pow2_lut_arbiter.sv
// Round-robin shared 2^(x/256)-1 LUT (8-bit in, 9-bit out) with a 2-stage
// registered pipeline; each result carries the issuing requester's index.
module pow2_lut_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic                 clock,
    input  logic                 resetN,
    pow2_lut_arbiter_if.slave    bus
);
    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int F    = 56;

    // Table is built at elaboration: 2^(1/2^j) by repeated integer square
    // roots in Q56, then products per set bit, rounded to nearest Q9.
    function automatic logic [255:0][8:0] build_lut();
        logic [8:0][127:0]  rt;
        logic [127:0]       v, r, t, p;
        logic [255:0][8:0]  tab;
        rt    = '0;
        tab   = '0;
        rt[0] = 128'd2 << F;
        for (int j = 1; j <= 8; j++) begin
            v = rt[j-1] << F;
            r = '0;
            for (int b = 60; b >= 0; b--) begin
                t = r | (128'd1 << b);
                if (t * t <= v) r = t;
            end
            rt[j] = r;
        end
        for (int x = 0; x < 256; x++) begin
            p = 128'd1 << F;
            for (int b = 0; b < 8; b++)
                if (x[b]) p = (p * rt[8-b]) >> F;
            r = ((p - (128'd1 << F)) + (128'd1 << (F-10))) >> (F-9);
            tab[x] = r[8:0];
        end
        return tab;
    endfunction

    localparam logic [255:0][8:0] LUT = build_lut();

    logic [ID_W-1:0]          r_rr_ptr;
    logic                     r_s1_valid;
    logic [7:0]               r_s1_frac;
    logic [ID_W-1:0]          r_s1_id;
    logic                     r_s2_valid;
    logic [8:0]               r_s2_data;
    logic [ID_W-1:0]          r_s2_id;

    logic                     w_s2_adv;
    logic                     w_s1_adv;
    logic                     w_any;
    logic                     w_take;
    logic [ID_W-1:0]          w_win;
    logic [NUM_REQ-1:0][7:0]  w_frac_v;

    assign w_frac_v = bus.in_frac;
    assign w_s2_adv = !r_s2_valid || bus.out_ready;
    assign w_s1_adv = !r_s1_valid || w_s2_adv;
    // Gating with resetN keeps in_ready low for the whole reset window.
    assign w_take   = w_any && w_s1_adv && resetN;

    always_comb begin
        int idx;
        idx   = 0;
        w_any = 1'b0;
        w_win = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(r_rr_ptr) + k) % NUM_REQ;
            if (!w_any && bus.in_valid[ID_W'(idx)]) begin
                w_any = 1'b1;
                w_win = ID_W'(idx);
            end
        end
    end

    always_comb begin
        bus.in_ready = '0;
        for (int k = 0; k < NUM_REQ; k++)
            bus.in_ready[k] = w_take && (w_win == ID_W'(k));
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            r_rr_ptr   <= '0;
            r_s1_valid <= 1'b0;
            r_s1_frac  <= '0;
            r_s1_id    <= '0;
            r_s2_valid <= 1'b0;
            r_s2_data  <= '0;
            r_s2_id    <= '0;
        end else begin
            if (w_s2_adv) begin
                r_s2_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_s2_data <= LUT[r_s1_frac];
                    r_s2_id   <= r_s1_id;
                end
            end
            if (w_s1_adv) begin
                r_s1_valid <= w_take;
                if (w_take) begin
                    r_s1_frac <= w_frac_v[w_win];
                    r_s1_id   <= w_win;
                end
            end
            if (w_take) begin
                if (w_win == ID_W'(NUM_REQ-1)) r_rr_ptr <= '0;
                else                           r_rr_ptr <= w_win + 1'b1;
            end
        end
    end

    assign bus.out_valid = r_s2_valid;
    assign bus.out_data  = r_s2_data;
    assign bus.out_id    = r_s2_id;
endmodule

// File: tb/tb_pow2_lut_arbiter.sv
// Randomized bench for pow2_lut_arbiter against a queue-based model: a
// 2-deep in-order pipe whose head is presentable 2 edges after acceptance.
module tb_pow2_lut_arbiter;
    localparam int N   = 4;
    localparam int IDW = 2;

    logic clock  = 1'b0;
    logic resetN = 1'b0;
    always #5 clock = ~clock;

    pow2_lut_arbiter_if #(.NUM_REQ(N)) bus();
    pow2_lut_arbiter #(.NUM_REQ(N)) dut (.clock(clock), .resetN(resetN), .bus(bus));

    typedef struct { int frac; int id; int age; } item_t;
    item_t q[$];
    int    rr;
    int    errors = 0;
    int    checks = 0;

    logic [N-1:0]   exp_rdy;
    logic           exp_vld;
    logic [8:0]     exp_data;
    logic [IDW-1:0] exp_id;
    bit             pend, pend_pop, pend_push;
    item_t          pend_item;
    int             pend_win;

    function automatic logic [8:0] lut_ref(input int x);
        real v;
        v = ($pow(2.0, real'(x) / 256.0) - 1.0) * 512.0;
        return 9'($rtoi(v + 0.5));
    endfunction

    task automatic model_reset();
        q.delete();
        rr   = 0;
        pend = 0;
    endtask

    task automatic commit();
        if (!pend) return;
        if (pend_pop) void'(q.pop_front());
        foreach (q[i]) q[i].age++;
        if (pend_push) begin
            q.push_back(pend_item);
            rr = (pend_win + 1) % N;
        end
        pend = 0;
    endtask

    // Drive one cycle at the negedge and compute what the DUT should show now.
    task automatic cyc(input logic [N-1:0] v, input logic [N*8-1:0] f, input logic ordy);
        int  win;
        bit  grant;
        commit();
        @(negedge clock);
        bus.in_valid  = v;
        bus.in_frac   = f;
        bus.out_ready = ordy;
        #1;
        exp_rdy = '0; exp_vld = 1'b0; exp_data = '0; exp_id = '0;
        if (!resetN) begin
            model_reset();
            return;
        end
        if (q.size() > 0) begin
            exp_vld  = (q[0].age >= 2);
            exp_data = lut_ref(q[0].frac);
            exp_id   = IDW'(q[0].id);
        end
        win = -1;
        for (int k = 0; k < N; k++)
            if (win < 0 && v[(rr + k) % N]) win = (rr + k) % N;
        grant = (win >= 0) && (q.size() < 2 || ordy);
        if (grant) exp_rdy = N'(1) << win;
        pend      = 1;
        pend_pop  = exp_vld && ordy;
        pend_push = grant;
        pend_win  = win;
        if (grant) pend_item = '{int'((f >> (8 * win)) & 32'hFF), win, 1};
    endtask

    task automatic do_reset();
        @(negedge clock);
        bus.in_valid = '0;
        resetN = 1'b0;
        #2;
        resetN = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        resetN = 1'b0;
        for (int c = 0; c < 3; c++) begin
            cyc(4'hF, $urandom, 1'b1);
            checks++; if (bus.in_ready !== 4'h0) begin errors++; $display("FAIL reset_in_ready got=%b exp=0000", bus.in_ready); end
            checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
            checks++; if ({bus.out_data, bus.out_id} !== 11'h0) begin errors++; $display("FAIL reset_out_data_id got=%h/%0d exp=000/0", bus.out_data, bus.out_id); end
        end
        bus.in_valid = '0;
        resetN = 1'b1;
        model_reset();
    endtask

    task automatic test_single();
        int acc_c = -1, out_c = -1;
        for (int c = 0; c < 5; c++) begin
            cyc((c == 0) ? 4'b0001 : 4'b0000, 32'h0000_0080, 1'b1);
            checks++; if (bus.in_ready !== exp_rdy) begin errors++; $display("FAIL single_in_ready got=%b exp=%b", bus.in_ready, exp_rdy); end
            checks++; if (bus.out_valid !== exp_vld) begin errors++; $display("FAIL single_out_valid got=%b exp=%b", bus.out_valid, exp_vld); end
            if (exp_vld) begin checks++; if ({bus.out_data, bus.out_id} !== {exp_data, exp_id}) begin errors++; $display("FAIL single_data got=%h/%0d exp=%h/%0d", bus.out_data, bus.out_id, exp_data, exp_id); end end
            if (bus.in_ready[0] && acc_c < 0) acc_c = c;
            if (bus.out_valid && out_c < 0) begin
                out_c = c;
                checks++; if ({bus.out_data, bus.out_id} !== {9'h0D4, 2'd0}) begin errors++; $display("FAIL single_0x80 got=%h/%0d exp=0d4/0", bus.out_data, bus.out_id); end
            end
        end
        checks++; if (acc_c != 0 || out_c != 2) begin errors++; $display("FAIL single_latency got=accept@%0d out@%0d exp=accept@0 out@2", acc_c, out_c); end
    endtask

    task automatic test_back_to_back();
        logic [8:0] got[$];
        for (int c = 0; c < 6; c++) begin
            cyc((c < 2) ? 4'b0010 : 4'b0000, (c == 0) ? 32'h0000_FF00 : 32'h0000_0000, 1'b1);
            checks++; if (bus.in_ready !== exp_rdy) begin errors++; $display("FAIL b2b_in_ready got=%b exp=%b", bus.in_ready, exp_rdy); end
            checks++; if (bus.out_valid !== exp_vld) begin errors++; $display("FAIL b2b_out_valid got=%b exp=%b", bus.out_valid, exp_vld); end
            if (exp_vld) begin checks++; if ({bus.out_data, bus.out_id} !== {exp_data, exp_id}) begin errors++; $display("FAIL b2b_data got=%h/%0d exp=%h/%0d", bus.out_data, bus.out_id, exp_data, exp_id); end end
            if (bus.out_valid) got.push_back(bus.out_data);
        end
        checks++;
        if (got.size() != 2 || got[0] !== 9'h1FD || got[1] !== 9'h000) begin
            errors++; $display("FAIL b2b_sequence got=%0d results first=%h exp=1fd,000", got.size(), (got.size() > 0) ? got[0] : 9'h0);
        end
    endtask

    task automatic test_round_robin();
        int exp_order[6] = '{0, 1, 2, 3, 0, 1};
        do_reset();
        for (int c = 0; c < 10; c++) begin
            cyc((c < 6) ? 4'hF : 4'h0, $urandom, 1'b1);
            checks++; if (bus.in_ready !== exp_rdy) begin errors++; $display("FAIL rr_in_ready got=%b exp=%b", bus.in_ready, exp_rdy); end
            checks++; if (bus.out_valid !== exp_vld) begin errors++; $display("FAIL rr_out_valid got=%b exp=%b", bus.out_valid, exp_vld); end
            if (exp_vld) begin checks++; if ({bus.out_data, bus.out_id} !== {exp_data, exp_id}) begin errors++; $display("FAIL rr_data got=%h/%0d exp=%h/%0d", bus.out_data, bus.out_id, exp_data, exp_id); end end
            if (c < 6) begin
                checks++; if (bus.in_ready !== (N'(1) << exp_order[c])) begin errors++; $display("FAIL rr_order cycle=%0d got=%b exp_req=%0d", c, bus.in_ready, exp_order[c]); end
            end
        end
    endtask

    task automatic test_stall();
        for (int c = 0; c < 18; c++) begin
            cyc((c < 12) ? 4'(($urandom % 15) + 1) : 4'h0, $urandom, !(c >= 4 && c < 9));
            checks++; if (bus.in_ready !== exp_rdy) begin errors++; $display("FAIL stall_in_ready got=%b exp=%b", bus.in_ready, exp_rdy); end
            checks++; if (bus.out_valid !== exp_vld) begin errors++; $display("FAIL stall_out_valid got=%b exp=%b", bus.out_valid, exp_vld); end
            if (exp_vld) begin checks++; if ({bus.out_data, bus.out_id} !== {exp_data, exp_id}) begin errors++; $display("FAIL stall_data got=%h/%0d exp=%h/%0d", bus.out_data, bus.out_id, exp_data, exp_id); end end
            if (c >= 6 && c < 9) begin
                checks++; if (bus.in_ready !== 4'h0) begin errors++; $display("FAIL stall_full_in_ready got=%b exp=0000", bus.in_ready); end
            end
        end
    endtask

    task automatic test_wrap();
        int n = 0;
        bit seen = 0;
        while (!seen && n < 6) begin
            cyc(4'b1000, $urandom, 1'b1);
            checks++; if (bus.in_ready !== exp_rdy) begin errors++; $display("FAIL wrap_in_ready got=%b exp=%b", bus.in_ready, exp_rdy); end
            seen = exp_rdy[3];
            n++;
        end
        checks++; if (!seen) begin errors++; $display("FAIL wrap_req3_timeout got=no grant exp=grant"); end
        cyc(4'b1001, $urandom, 1'b1);
        checks++; if (bus.in_ready !== 4'b0001) begin errors++; $display("FAIL wrap_3_to_0 got=%b exp=0001", bus.in_ready); end
        for (int c = 0; c < 4; c++) begin
            cyc(4'h0, '0, 1'b1);
            checks++; if (bus.out_valid !== exp_vld) begin errors++; $display("FAIL wrap_out_valid got=%b exp=%b", bus.out_valid, exp_vld); end
            if (exp_vld) begin checks++; if ({bus.out_data, bus.out_id} !== {exp_data, exp_id}) begin errors++; $display("FAIL wrap_data got=%h/%0d exp=%h/%0d", bus.out_data, bus.out_id, exp_data, exp_id); end end
        end
    endtask

    task automatic test_async_reset();
        int out_c = -1;
        for (int c = 0; c < 4; c++) cyc(4'hF, $urandom, 1'b0);
        checks++; if (bus.out_valid !== 1'b1 || bus.in_ready !== 4'h0) begin errors++; $display("FAIL areset_prefill got=vld%b rdy%b exp=vld1 rdy0000", bus.out_valid, bus.in_ready); end
        #1 resetN = 1'b0;
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL areset_out_valid got=%b exp=0", bus.out_valid); end
        checks++; if (bus.in_ready !== 4'h0) begin errors++; $display("FAIL areset_in_ready got=%b exp=0000", bus.in_ready); end
        bus.in_valid = '0;
        model_reset();
        #1 resetN = 1'b1;
        for (int c = 0; c < 5; c++) begin
            cyc((c == 0) ? 4'b0100 : 4'b0000, $urandom, 1'b1);
            checks++; if (bus.in_ready !== exp_rdy) begin errors++; $display("FAIL areset_post_in_ready got=%b exp=%b", bus.in_ready, exp_rdy); end
            checks++; if (bus.out_valid !== exp_vld) begin errors++; $display("FAIL areset_post_out_valid got=%b exp=%b", bus.out_valid, exp_vld); end
            if (exp_vld) begin checks++; if ({bus.out_data, bus.out_id} !== {exp_data, exp_id}) begin errors++; $display("FAIL areset_post_data got=%h/%0d exp=%h/%0d", bus.out_data, bus.out_id, exp_data, exp_id); end end
            if (bus.out_valid && out_c < 0) out_c = c;
        end
        checks++; if (out_c != 2) begin errors++; $display("FAIL areset_latency got=%0d exp=2", out_c); end
    endtask

    task automatic test_sweep();
        int f = 0, n = 0, des;
        logic [N*8-1:0] fv;
        des = $urandom_range(0, N-1);
        while (f < 256 && n < 4000) begin
            fv = $urandom;
            fv[8*des +: 8] = 8'(f);
            cyc(4'($urandom) | (N'(1) << des), fv, ($urandom % 4) != 0);
            checks++; if (bus.in_ready !== exp_rdy) begin errors++; $display("FAIL sweep_in_ready got=%b exp=%b", bus.in_ready, exp_rdy); end
            checks++; if (bus.out_valid !== exp_vld) begin errors++; $display("FAIL sweep_out_valid got=%b exp=%b", bus.out_valid, exp_vld); end
            if (exp_vld) begin checks++; if ({bus.out_data, bus.out_id} !== {exp_data, exp_id}) begin errors++; $display("FAIL sweep_data got=%h/%0d exp=%h/%0d", bus.out_data, bus.out_id, exp_data, exp_id); end end
            if (exp_rdy[des]) begin
                f++;
                des = $urandom_range(0, N-1);
            end
            n++;
        end
        checks++; if (f < 256) begin errors++; $display("FAIL sweep_timeout got=%0d fractions exp=256", f); end
        for (int c = 0; c < 4; c++) begin
            cyc(4'h0, '0, 1'b1);
            checks++; if (bus.out_valid !== exp_vld) begin errors++; $display("FAIL sweep_drain_valid got=%b exp=%b", bus.out_valid, exp_vld); end
            if (exp_vld) begin checks++; if ({bus.out_data, bus.out_id} !== {exp_data, exp_id}) begin errors++; $display("FAIL sweep_drain_data got=%h/%0d exp=%h/%0d", bus.out_data, bus.out_id, exp_data, exp_id); end end
        end
        checks++; if (q.size() != 0) begin errors++; $display("FAIL sweep_residue got=%0d exp=0", q.size()); end
    endtask

    initial begin
        bus.in_valid  = '0;
        bus.in_frac   = '0;
        bus.out_ready = 1'b1;
        model_reset();
        test_reset();
        test_single();
        test_back_to_back();
        test_round_robin();
        test_stall();
        test_wrap();
        test_async_reset();
        test_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule
